// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared constants and state encoding for the fetch sequencer.
package fetch_sequencer_pkg;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_1000;
    localparam logic [3:0]  JUMP_HI          = 4'b0000;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, decode and execute signals around the fetch sequencer.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic        zero;
    logic        branch_sel;
    logic        jump_sel;
    logic        flush;
    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr, flush,
        input  imem_ack, imem_rdata, id_ready, ex_valid, ex_instr, ex_pc, zero, branch_sel, jump_sel
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, flush,
        output imem_ack, imem_rdata, id_ready, ex_valid, ex_instr, ex_pc, zero, branch_sel, jump_sel
    );
endinterface

// File: rtl/fetch_sequencer_pc_target_calc.sv
// pc_target_calc: jump/branch targets from the execute stage and the redirect decision.
module pc_target_calc
    import fetch_sequencer_pkg::*;
(
    input  logic        ex_valid_i,
    input  logic [31:0] ex_instr_i,
    input  logic [31:0] ex_pc_i,
    input  logic        zero_i,
    input  logic        branch_sel_i,
    input  logic        jump_sel_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);
    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic        unused_opcode;
    assign jump_tgt      = {JUMP_HI, ex_instr_i[25:0], 2'b00};
    assign branch_tgt    = ex_pc_i + 32'd4 + {{14{ex_instr_i[15]}}, ex_instr_i[15:0], 2'b00};
    assign redirect_o    = ex_valid_i & (jump_sel_i | (branch_sel_i & zero_i));
    assign target_o      = jump_sel_i ? jump_tgt : branch_tgt;
    assign unused_opcode = ^ex_instr_i[31:26];
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch with a one-entry decode buffer
// and branch/jump redirect handling.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus_io
);
    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:2] addr_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        flush_q;
    logic        redirect;
    logic [31:0] target;
    pc_target_calc u_calc (
        .ex_valid_i  (bus_io.ex_valid),
        .ex_instr_i  (bus_io.ex_instr),
        .ex_pc_i     (bus_io.ex_pc),
        .zero_i      (bus_io.zero),
        .branch_sel_i(bus_io.branch_sel),
        .jump_sel_i  (bus_io.jump_sel),
        .redirect_o  (redirect),
        .target_o    (target)
    );
    // DRAIN keeps presenting the abandoned address until memory answers it
    assign bus_io.imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign bus_io.imem_addr = {(state_q == DRAIN) ? addr_q : pc_q[31:2], 2'b00};
    assign bus_io.if_valid  = state_q == HOLD;
    assign bus_io.if_pc     = if_pc_q;
    assign bus_io.if_instr  = if_instr_q;
    assign bus_io.flush     = flush_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            addr_q     <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= redirect;
            case (state_q)
                BOOT: begin
                    state_q <= REQ;
                    if (redirect) pc_q <= target;
                end
                REQ: begin
                    if (redirect) begin
                        pc_q    <= target;
                        addr_q  <= pc_q[31:2];
                        state_q <= bus_io.imem_ack ? REQ : DRAIN;
                    end else if (bus_io.imem_ack) begin
                        if_instr_q <= bus_io.imem_rdata;
                        if_pc_q    <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) pc_q <= target;
                    if (redirect || bus_io.id_ready) state_q <= REQ;
                end
                default: begin
                    if (redirect) pc_q <= target;
                    if (bus_io.imem_ack) state_q <= REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    fetch_sequencer_if bus ();
    fetch_sequencer #(.RESET_VECTOR(32'h0000_1000)) dut (.clk(clk), .rst(rst), .bus_io(bus));
    int total = 0;
    int bad = 0;
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        idr, exv, br, jp, z;
        logic [31:0] epc, ins;
        logic        req;
        logic [31:0] addr;
        logic        val;
        logic [31:0] ipc, iins;
        logic        fl;
    } vec_t;
    vec_t tv[11];
    // reference model: an outstanding request (optionally to be dropped) and a one-entry buffer
    logic        m_boot, m_busy, m_drop, m_buf, m_flush;
    logic [31:0] m_pc, m_addr, m_bpc, m_bins;

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic idr, exv, br, jp, z,
                         input logic [31:0] epc, ins);
        bus.imem_ack   = ack;
        bus.imem_rdata = rdata;
        bus.id_ready   = idr;
        bus.ex_valid   = exv;
        bus.branch_sel = br;
        bus.jump_sel   = jp;
        bus.zero       = z;
        bus.ex_pc      = epc;
        bus.ex_instr   = ins;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic req, input logic [31:0] addr, input logic val,
                           input logic [31:0] ipc, iins, input logic fl);
        chk({nm, ".req"}, {31'b0, bus.imem_req}, {31'b0, req});
        if (req) chk({nm, ".addr"}, bus.imem_addr, addr);
        chk({nm, ".valid"}, {31'b0, bus.if_valid}, {31'b0, val});
        chk({nm, ".if_pc"}, bus.if_pc, ipc);
        chk({nm, ".if_instr"}, bus.if_instr, iins);
        chk({nm, ".flush"}, {31'b0, bus.flush}, {31'b0, fl});
    endtask

    task automatic model_reset();
        m_boot = 1; m_busy = 0; m_drop = 0; m_buf = 0; m_flush = 0;
        m_pc = 32'h1000; m_addr = 0; m_bpc = 0; m_bins = 0;
    endtask

    task automatic model_step(input logic ack, input logic [31:0] rdata, input logic idr, exv, br, jp, z,
                              input logic [31:0] epc, ins);
        logic        redir;
        logic [31:0] tgt;
        redir = exv && (jp || (br && z));
        tgt = jp ? (ins % 32'h0400_0000) * 32'd4
                 : epc + 32'd4 + 32'(int'($signed(ins[15:0])) * 4);
        m_flush = redir;
        if (m_boot) begin
            m_boot = 0;
            if (redir) m_pc = tgt;
            m_busy = 1; m_drop = 0; m_addr = m_pc;
        end else if (m_busy) begin
            if (redir) begin
                m_pc = tgt;
                if (ack) begin m_drop = 0; m_addr = m_pc; end
                else m_drop = 1;
            end else if (ack) begin
                if (m_drop) begin m_drop = 0; m_addr = m_pc; end
                else begin
                    m_buf = 1; m_bpc = m_addr; m_bins = rdata; m_pc = m_addr + 32'd4; m_busy = 0;
                end
            end
        end else if (redir || idr) begin
            if (redir) m_pc = tgt;
            m_buf = 0; m_busy = 1; m_drop = 0; m_addr = m_pc;
        end
    endtask

    initial begin
        tv[0]  = '{0, 32'h0,        0, 0, 0, 0, 0, 32'h0,    32'h0,        1, 32'h1000, 0, 32'h0,    32'h0,        0};
        tv[1]  = '{1, 32'hAAAA0001, 1, 0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,    1, 32'h1000, 32'hAAAA0001, 0};
        tv[2]  = '{0, 32'h0,        1, 0, 0, 0, 0, 32'h0,    32'h0,        1, 32'h1004, 0, 32'h1000, 32'hAAAA0001, 0};
        tv[3]  = '{1, 32'hBBBB0002, 0, 0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,    1, 32'h1004, 32'hBBBB0002, 0};
        tv[4]  = '{0, 32'h0,        1, 1, 1, 0, 1, 32'h1008, 32'h0000FFFE, 1, 32'h1004, 0, 32'h1004, 32'hBBBB0002, 1};
        tv[5]  = '{0, 32'h0,        0, 1, 1, 0, 0, 32'h1008, 32'h0000FFFE, 1, 32'h1004, 0, 32'h1004, 32'hBBBB0002, 0};
        tv[6]  = '{0, 32'h0,        0, 1, 1, 1, 1, 32'h2000, 32'h00000400, 1, 32'h1004, 0, 32'h1004, 32'hBBBB0002, 1};
        tv[7]  = '{0, 32'h0,        0, 0, 0, 0, 0, 32'h0,    32'h0,        1, 32'h1004, 0, 32'h1004, 32'hBBBB0002, 0};
        tv[8]  = '{0, 32'h0,        0, 0, 1, 1, 1, 32'h0,    32'h0,        1, 32'h1004, 0, 32'h1004, 32'hBBBB0002, 0};
        tv[9]  = '{1, 32'hDEAD0000, 0, 0, 0, 0, 0, 32'h0,    32'h0,        1, 32'h1000, 0, 32'h1004, 32'hBBBB0002, 0};
        tv[10] = '{1, 32'hCCCC0003, 0, 0, 0, 0, 0, 32'h0,    32'h0,        0, 32'h0,    1, 32'h1000, 32'hCCCC0003, 0};
        idle();
        #1 rst = 1'b1;
        #7;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        #4 rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(tv[i].ack, tv[i].rdata, tv[i].idr, tv[i].exv, tv[i].br, tv[i].jp, tv[i].z, tv[i].epc, tv[i].ins);
            step();
            chk_all($sformatf("vec%0d", i), tv[i].req, tv[i].addr, tv[i].val, tv[i].ipc, tv[i].iins, tv[i].fl);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
            chk_all($sformatf("hold%0d", i), 1'b0, 32'h0, 1'b1, 32'h1000, 32'hCCCC0003, 1'b0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_all("release", 1'b1, 32'h1004, 1'b0, 32'h1000, 32'hCCCC0003, 1'b0);
        drive(1'b1, 32'hEEEE0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00000020);
        step();
        chk_all("ack_redir", 1'b1, 32'h80, 1'b0, 32'h1000, 32'hCCCC0003, 1'b1);
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h00000002);
        step();
        chk_all("wrap_tgt", 1'b1, 32'hFFFFFFFC, 1'b0, 32'h1000, 32'hCCCC0003, 1'b1);
        drive(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_all("wrap_hold", 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 32'h12345678, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_all("wrap_next", 1'b1, 32'h0, 1'b0, 32'hFFFFFFFC, 32'h12345678, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00000040);
        step();
        chk_all("drain", 1'b1, 32'h0, 1'b0, 32'hFFFFFFFC, 32'h12345678, 1'b1);
        idle();
        #3 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3 rst = 1'b0;
        #1;
        chk_all("boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        chk_all("boot_ack", 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0, 1'b0);
        idle();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00000010);
        step();
        chk_all("boot_redir", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();
        step();
        chk_all("flush_pulse", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        ack, idr, exv, br, jp, z;
            logic [31:0] rdata, epc, ins;
            ack = $urandom_range(0, 2) == 0;
            idr = 1'($urandom_range(0, 1));
            exv = 1'($urandom_range(0, 1));
            br = $urandom_range(0, 3) == 0;
            jp = $urandom_range(0, 7) == 0;
            z = 1'($urandom_range(0, 1));
            rdata = $urandom();
            epc = $urandom() & 32'hFFFF_FFFC;
            ins = $urandom();
            drive(ack, rdata, idr, exv, br, jp, z, epc, ins);
            model_step(ack, rdata, idr, exv, br, jp, z, epc, ins);
            step();
            chk_all($sformatf("rnd%0d", i), m_busy, m_addr & 32'hFFFF_FFFC, m_buf, m_bpc, m_bins, m_flush);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
